tdc_meas_ctrl: RTL and testbench

Measurement sequencer for one TDC channel. It arms the channel, counts coarse clock cycles between the start and stop hits, and pulses `go` into the start-edge and stop-edge decoders. It collects both fine codes and presents one timestamp record on a valid/ready handshake. It sits between the two edge decoders and the readout/UART packer.

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_fin_collect.sv | 67 ++++++
 rtl/tdc_meas_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement sequencer.
package tdc_pkg;

  localparam int unsigned NUM_DECODE_DEF = 8;
  localparam int unsigned COARSE_W_DEF   = 16;
  localparam int unsigned STOP_TMO_DEF   = 1000;
  localparam int unsigned DEC_TMO_DEF    = 8;
  localparam int unsigned ERR_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DECODE = 3'd3,
    ST_DONE   = 3'd4,
    ST_CLEAR  = 3'd5
  } tdc_state_t;

  localparam logic [ERR_W-1:0] ERR_OK       = 2'b00;
  localparam logic [ERR_W-1:0] ERR_STOP_TMO = 2'b01;
  localparam logic [ERR_W-1:0] ERR_DEC_TMO  = 2'b10;
  localparam logic [ERR_W-1:0] ERR_CODE     = 2'b11;

endpackage

// File: rtl/tdc_fin_collect.sv
// Sticky decoder-finish flags, fine-code latches and the decode timeout timer.
module tdc_fin_collect
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_DECODE = NUM_DECODE_DEF,
  parameter int unsigned DEC_TMO    = DEC_TMO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_tmr_run,
  input  logic                  i_fin_start,
  input  logic                  i_fin_stop,
  input  logic [NUM_DECODE-1:0] i_fine_start,
  input  logic [NUM_DECODE-1:0] i_fine_stop,
  output logic                  o_both_done,
  output logic                  o_tmo,
  output logic [NUM_DECODE-1:0] o_code_start,
  output logic [NUM_DECODE-1:0] o_code_stop
);

  localparam int unsigned TMR_W = $clog2(DEC_TMO + 1);

  logic                  r_flag_start;
  logic                  r_flag_stop;
  logic [NUM_DECODE-1:0] r_code_start;
  logic [NUM_DECODE-1:0] r_code_stop;
  logic [TMR_W-1:0]      r_tmr;

  // First finish pulse of each decoder wins; its code is sampled in that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flag_start <= 1'b0;
      r_flag_stop  <= 1'b0;
      r_code_start <= '0;
      r_code_stop  <= '0;
      r_tmr        <= '0;
    end else if (i_clr) begin
      r_flag_start <= 1'b0;
      r_flag_stop  <= 1'b0;
      r_code_start <= '0;
      r_code_stop  <= '0;
      r_tmr        <= '0;
    end else begin
      if (i_en && i_fin_start && !r_flag_start) begin
        r_flag_start <= 1'b1;
        r_code_start <= i_fine_start;
      end
      if (i_en && i_fin_stop && !r_flag_stop) begin
        r_flag_stop <= 1'b1;
        r_code_stop <= i_fine_stop;
      end
      if (i_tmr_run) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end else begin
        r_tmr <= '0;
      end
    end
  end

  assign o_both_done  = r_flag_start & r_flag_stop;
  assign o_tmo        = i_tmr_run && (r_tmr == TMR_W'(DEC_TMO - 1));
  assign o_code_start = r_code_start;
  assign o_code_stop  = r_code_stop;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for one TDC channel: arm, coarse count, decoder handshake, record out.
// Optional zero-code check enabled by defining TDC_CODE_CHECK_EN.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_DECODE = NUM_DECODE_DEF,
  parameter int unsigned COARSE_W   = COARSE_W_DEF,
  parameter int unsigned STOP_TMO   = STOP_TMO_DEF,
  parameter int unsigned DEC_TMO    = DEC_TMO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  start_hit,
  input  logic                  stop_hit,
  output logic                  dec_go_start,
  output logic                  dec_go_stop,
  output logic                  dec_rst,
  input  logic                  dec_fin_start,
  input  logic                  dec_fin_stop,
  input  logic [NUM_DECODE-1:0] fine_start,
  input  logic [NUM_DECODE-1:0] fine_stop,
  output logic                  busy,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic [COARSE_W-1:0]   meas_coarse,
  output logic [NUM_DECODE-1:0] meas_fine_start,
  output logic [NUM_DECODE-1:0] meas_fine_stop,
  output logic [ERR_W-1:0]      meas_err
);

  tdc_state_t            r_state;
  logic                  r_go_start;
  logic                  r_go_stop;
  logic                  r_dec_rst;
  logic                  r_busy;
  logic                  r_valid;
  logic [COARSE_W-1:0]   r_coarse;
  logic [NUM_DECODE-1:0] r_fine_start;
  logic [NUM_DECODE-1:0] r_fine_stop;
  logic [ERR_W-1:0]      r_err;

  logic                  w_both_done;
  logic                  w_tmo;
  logic [NUM_DECODE-1:0] w_code_start;
  logic [NUM_DECODE-1:0] w_code_stop;
  logic [ERR_W-1:0]      w_code_err;

  // Finishes may precede the stop go, so collection runs through RUN as well.
  tdc_fin_collect #(
    .NUM_DECODE (NUM_DECODE),
    .DEC_TMO    (DEC_TMO)
  ) u_fin_collect (
    .clk          (clk),
    .rst          (rst),
    .i_en         ((r_state == ST_RUN) || (r_state == ST_DECODE)),
    .i_clr        (r_state == ST_CLEAR),
    .i_tmr_run    (r_state == ST_DECODE),
    .i_fin_start  (dec_fin_start),
    .i_fin_stop   (dec_fin_stop),
    .i_fine_start (fine_start),
    .i_fine_stop  (fine_stop),
    .o_both_done  (w_both_done),
    .o_tmo        (w_tmo),
    .o_code_start (w_code_start),
    .o_code_stop  (w_code_stop)
  );

`ifdef TDC_CODE_CHECK_EN
  assign w_code_err = ((w_code_start == '0) || (w_code_stop == '0)) ? ERR_CODE : ERR_OK;
`else
  assign w_code_err = ERR_OK;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_go_start   <= 1'b0;
      r_go_stop    <= 1'b0;
      r_dec_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_coarse     <= '0;
      r_fine_start <= '0;
      r_fine_stop  <= '0;
      r_err        <= ERR_OK;
    end else begin
      r_go_start <= 1'b0;
      r_go_stop  <= 1'b0;
      r_dec_rst  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state  <= ST_ARMED;
            r_busy   <= 1'b1;
            r_err    <= ERR_OK;
            r_coarse <= '0;
          end
        end
        ST_ARMED: begin
          if (start_hit) begin
            r_go_start <= 1'b1;
            r_coarse   <= '0;
            if (stop_hit) begin
              r_go_stop <= 1'b1;
              r_state   <= ST_DECODE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Counting through the stop cycle makes the record equal stop minus start edges.
          r_coarse <= r_coarse + COARSE_W'(1);
          if (stop_hit) begin
            r_go_stop <= 1'b1;
            r_state   <= ST_DECODE;
          end else if (r_coarse == COARSE_W'(STOP_TMO - 1)) begin
            r_err        <= ERR_STOP_TMO;
            r_valid      <= 1'b1;
            r_fine_start <= w_code_start;
            r_fine_stop  <= w_code_stop;
            r_state      <= ST_DONE;
          end
        end
        ST_DECODE: begin
          if (w_both_done) begin
            r_err        <= w_code_err;
            r_valid      <= 1'b1;
            r_fine_start <= w_code_start;
            r_fine_stop  <= w_code_stop;
            r_state      <= ST_DONE;
          end else if (w_tmo) begin
            r_err        <= ERR_DEC_TMO;
            r_valid      <= 1'b1;
            r_fine_start <= w_code_start;
            r_fine_stop  <= w_code_stop;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_valid && meas_ready) begin
            r_valid   <= 1'b0;
            r_dec_rst <= 1'b1;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dec_go_start    = r_go_start;
  assign dec_go_stop     = r_go_stop;
  assign dec_rst         = r_dec_rst;
  assign busy            = r_busy;
  assign meas_valid      = r_valid;
  assign meas_coarse     = r_coarse;
  assign meas_fine_start = r_fine_start;
  assign meas_fine_stop  = r_fine_stop;
  assign meas_err        = r_err;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed self-checking bench for tdc_meas_ctrl; expected err for the zero-code case
// follows TDC_CODE_CHECK_EN.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, start_hit, stop_hit;
  logic        dec_go_start, dec_go_stop, dec_rst;
  logic        dec_fin_start, dec_fin_stop;
  logic [7:0]  fine_start, fine_stop;
  logic        busy, meas_valid, meas_ready;
  logic [15:0] meas_coarse;
  logic [7:0]  meas_fine_start, meas_fine_stop;
  logic [1:0]  meas_err;

  int n_chk  = 0;
  int n_fail = 0;
  int go_s_cnt, go_p_cnt, go_s_k, go_p_k, valid_k;

  tdc_meas_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .start_hit       (start_hit),
    .stop_hit        (stop_hit),
    .dec_go_start    (dec_go_start),
    .dec_go_stop     (dec_go_stop),
    .dec_rst         (dec_rst),
    .dec_fin_start   (dec_fin_start),
    .dec_fin_stop    (dec_fin_stop),
    .fine_start      (fine_start),
    .fine_stop       (fine_stop),
    .busy            (busy),
    .meas_valid      (meas_valid),
    .meas_ready      (meas_ready),
    .meas_coarse     (meas_coarse),
    .meas_fine_start (meas_fine_start),
    .meas_fine_stop  (meas_fine_stop),
    .meas_err        (meas_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int k);
    if (dec_go_start) begin go_s_cnt++; go_s_k = k; end
    if (dec_go_stop)  begin go_p_cnt++; go_p_k = k; end
  endtask

  // Arms, fires start at edge 0, then drives stop/finishes at the given edge indices (-1 = never).
  task automatic do_meas(input int stop_at, input int fs_at, input int fp_at,
                         input logic [7:0] cs, input logic [7:0] cp, input int max_cyc);
    go_s_cnt = 0; go_p_cnt = 0; go_s_k = -1; go_p_k = -1; valid_k = -1;
    arm = 1'b1; tick(); arm = 1'b0;
    start_hit = 1'b1; stop_hit = (stop_at == 0);
    tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    sample(0);
    for (int k = 1; k <= max_cyc; k++) begin
      stop_hit      = (k == stop_at);
      dec_fin_start = (k == fs_at);
      dec_fin_stop  = (k == fp_at);
      fine_start    = (k == fs_at) ? cs : 8'h00;
      fine_stop     = (k == fp_at) ? cp : 8'h00;
      tick();
      stop_hit = 1'b0; dec_fin_start = 1'b0; dec_fin_stop = 1'b0;
      fine_start = 8'h00; fine_stop = 8'h00;
      sample(k);
      if (meas_valid) begin
        valid_k = k;
        break;
      end
    end
    if (valid_k < 0) check_eq("valid_seen", 32'd0, 32'd1);
  endtask

  // Accept with ready=1: one dec_rst pulse in CLEAR, then back to IDLE.
  task automatic finish_rec(input string tag);
    tick();
    check_eq({tag, "_valid_drop"}, meas_valid, 1'b0);
    check_eq({tag, "_dec_rst"}, dec_rst, 1'b1);
    tick();
    check_eq({tag, "_dec_rst_end"}, dec_rst, 1'b0);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int bad;
    int gos;
    logic [1:0] exp_code_err;
    rst = 1'b0; arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0;
    dec_fin_start = 1'b0; dec_fin_stop = 1'b0; fine_start = 8'h00; fine_stop = 8'h00;
    meas_ready = 1'b1;
    tick(); tick();
    check_eq("rst_dec_rst", dec_rst, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", meas_valid, 1'b0);
    check_eq("rst_go", {dec_go_start, dec_go_stop}, 2'b00);
    rst = 1'b1;
    tick();
    check_eq("post_rst_dec_rst", dec_rst, 1'b0);

    // Stray hits in IDLE are ignored.
    start_hit = 1'b1; stop_hit = 1'b1; tick(); start_hit = 1'b0; stop_hit = 1'b0;
    check_eq("idle_ignore_go", {dec_go_start, dec_go_stop}, 2'b00);
    check_eq("idle_busy", busy, 1'b0);

    // 1: normal measurement
    do_meas(37, 4, 41, 8'd12, 8'd25, 100);
    check_eq("t1_go_s_cnt", go_s_cnt, 1);
    check_eq("t1_go_p_cnt", go_p_cnt, 1);
    check_eq("t1_go_p_k", go_p_k, 37);
    check_eq("t1_valid_k", valid_k, 42);
    check_eq("t1_coarse", meas_coarse, 16'd37);
    check_eq("t1_fs", meas_fine_start, 8'd12);
    check_eq("t1_fp", meas_fine_stop, 8'd25);
    check_eq("t1_err", meas_err, 2'b00);
    finish_rec("t1");

    // 2: simultaneous hits, finishes in the go cycle
    do_meas(0, 1, 1, 8'd7, 8'd200, 50);
    check_eq("t2_go_s_k", go_s_k, 0);
    check_eq("t2_go_p_k", go_p_k, 0);
    check_eq("t2_valid_k", valid_k, 2);
    check_eq("t2_coarse", meas_coarse, 16'd0);
    check_eq("t2_fs", meas_fine_start, 8'd7);
    check_eq("t2_fp", meas_fine_stop, 8'd200);
    check_eq("t2_err", meas_err, 2'b00);
    finish_rec("t2");

    // 3: stop timeout
    do_meas(-1, 4, -1, 8'd9, 8'd0, 1100);
    check_eq("t3_valid_k", valid_k, 1000);
    check_eq("t3_coarse", meas_coarse, 16'd1000);
    check_eq("t3_err", meas_err, 2'b01);
    check_eq("t3_go_p_cnt", go_p_cnt, 0);
    finish_rec("t3");

    // 4a: decode timeout with fin_stop withheld
    do_meas(10, 4, -1, 8'd5, 8'd0, 100);
    check_eq("t4a_err", meas_err, 2'b10);
    check_eq("t4a_tmo_delay", valid_k - go_p_k, 8);
    check_eq("t4a_coarse", meas_coarse, 16'd10);
    check_eq("t4a_fs", meas_fine_start, 8'd5);
    finish_rec("t4a");

    // 4b: fin_stop before fin_start, no timeout
    do_meas(10, 15, 12, 8'd44, 8'd33, 100);
    check_eq("t4b_valid_k", valid_k, 16);
    check_eq("t4b_err", meas_err, 2'b00);
    check_eq("t4b_fs", meas_fine_start, 8'd44);
    check_eq("t4b_fp", meas_fine_stop, 8'd33);
    finish_rec("t4b");

    // 5: backpressure with stray inputs during DONE
    meas_ready = 1'b0;
    do_meas(5, 2, 7, 8'h11, 8'h22, 100);
    check_eq("t5_valid_k", valid_k, 8);
    bad = 0; gos = 0;
    for (int i = 0; i < 20; i++) begin
      arm = (i % 3 == 0); start_hit = (i % 4 == 1); stop_hit = (i % 5 == 2);
      dec_fin_start = (i % 2 == 0); dec_fin_stop = (i % 2 == 1);
      fine_start = 8'(i * 7 + 1); fine_stop = 8'(i * 13 + 3);
      tick();
      arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0;
      dec_fin_start = 1'b0; dec_fin_stop = 1'b0; fine_start = 8'h00; fine_stop = 8'h00;
      if (!meas_valid || !busy || meas_coarse != 16'd5 || meas_fine_start != 8'h11 ||
          meas_fine_stop != 8'h22 || meas_err != 2'b00) bad++;
      if (dec_go_start || dec_go_stop || dec_rst) gos++;
    end
    check_eq("t5_record_stable", bad, 0);
    check_eq("t5_no_ctrl_pulse", gos, 0);
    meas_ready = 1'b1;
    finish_rec("t5");

    // 5b: reset mid-RUN
    arm = 1'b1; tick(); arm = 1'b0;
    start_hit = 1'b1; tick(); start_hit = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t5b_run_coarse", meas_coarse, 16'd4);
    rst = 1'b0;
    #1;
    check_eq("t5b_busy", busy, 1'b0);
    check_eq("t5b_dec_rst", dec_rst, 1'b1);
    check_eq("t5b_coarse", meas_coarse, 16'd0);
    check_eq("t5b_valid_err", {meas_valid, meas_err}, 3'b000);
    tick();
    rst = 1'b1;
    start_hit = 1'b1; tick(); start_hit = 1'b0;
    check_eq("t5b_idle_go", dec_go_start, 1'b0);
    check_eq("t5b_idle_busy", busy, 1'b0);

    // 6: zero stop code
`ifdef TDC_CODE_CHECK_EN
    exp_code_err = 2'b11;
`else
    exp_code_err = 2'b00;
`endif
    do_meas(3, 2, 5, 8'h40, 8'h00, 100);
    check_eq("t6_valid_k", valid_k, 6);
    check_eq("t6_err", meas_err, exp_code_err);
    check_eq("t6_fp", meas_fine_stop, 8'h00);
    finish_rec("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
